// File: rtl/handshake_sync_rx.sv
// Receive side of a two-phase toggle handshake: synchronizes src_req, captures src_data, presents it as a valid/ready word.
// Latency: m_tvalid rises SYNC_STAGES+1+SETTLE_CYCLES edges after src_req first samples a toggle.
// Backpressure: word and src_ack hold while m_tready is low; define HANDSHAKE_SYNC_RX_STATUS_EN for xfer_count/busy.
module handshake_sync_rx #(
    parameter int DW            = 8,
    parameter int SYNC_STAGES   = 2,
    parameter int SETTLE_CYCLES = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          src_req,
    input  logic [DW-1:0] src_data,
    output logic          src_ack,
    output logic [DW-1:0] m_tdata,
    output logic          m_tvalid,
    input  logic          m_tready
`ifdef HANDSHAKE_SYNC_RX_STATUS_EN
    ,
    output logic [15:0]   xfer_count,
    output logic          busy
`endif
);

    localparam logic [7:0] SETTLE_LOAD = (SETTLE_CYCLES > 0) ? 8'(SETTLE_CYCLES - 1) : 8'd0;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        VALID
    } state_t;

    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;

    state_t     state;
    logic [7:0] settle_cnt;
    logic       req_s;
    logic       pending;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], src_req};
        end
    end

    assign req_s   = sync_q[SYNC_STAGES-1];
    // A new word is waiting whenever the synchronized request disagrees with the ack we last returned.
    assign pending = req_s ^ src_ack;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            settle_cnt <= 8'd0;
            src_ack    <= 1'b0;
            m_tvalid   <= 1'b0;
            m_tdata    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pending) begin
                        if (SETTLE_CYCLES == 0) begin
                            m_tdata  <= src_data;
                            m_tvalid <= 1'b1;
                            state    <= VALID;
                        end else begin
                            settle_cnt <= SETTLE_LOAD;
                            state      <= SETTLE;
                        end
                    end
                end
                SETTLE: begin
                    if (settle_cnt == 8'd0) begin
                        m_tdata  <= src_data;
                        m_tvalid <= 1'b1;
                        state    <= VALID;
                    end else begin
                        settle_cnt <= settle_cnt - 8'd1;
                    end
                end
                VALID: begin
                    // Ack only on acceptance so the source keeps src_data held until the word is consumed.
                    if (m_tvalid && m_tready) begin
                        m_tvalid <= 1'b0;
                        src_ack  <= ~src_ack;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    m_tvalid <= 1'b0;
                end
            endcase
        end
    end

`ifdef HANDSHAKE_SYNC_RX_STATUS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            xfer_count <= 16'd0;
        end else if (m_tvalid && m_tready) begin
            xfer_count <= xfer_count + 16'd1;
        end
    end

    assign busy = (state != IDLE);
`endif

endmodule

// File: tb/tb_handshake_sync_rx.sv
// Bench for handshake_sync_rx: two instances (fast and settled) driven by a toggle-handshake source model.
module tb_handshake_sync_rx;

    localparam int S0 = 2;
    localparam int T0 = 0;
    localparam int S1 = 3;
    localparam int T1 = 3;

    logic       clk = 1'b0;
    logic       rst  [2];
    logic       req  [2];
    logic       ack  [2];
    logic       vld  [2];
    logic       rdy  [2];
    logic [7:0] din  [2];
    logic [7:0] dout [2];
`ifdef HANDSHAKE_SYNC_RX_STATUS_EN
    logic [15:0] cnt [2];
    logic        bsy [2];
`endif

    int lat [2];
    int stl [2];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    handshake_sync_rx #(.DW(8), .SYNC_STAGES(S0), .SETTLE_CYCLES(T0)) dut0 (
        .clk(clk), .rst(rst[0]), .src_req(req[0]), .src_data(din[0]), .src_ack(ack[0]),
        .m_tdata(dout[0]), .m_tvalid(vld[0]), .m_tready(rdy[0])
`ifdef HANDSHAKE_SYNC_RX_STATUS_EN
        , .xfer_count(cnt[0]), .busy(bsy[0])
`endif
    );

    handshake_sync_rx #(.DW(8), .SYNC_STAGES(S1), .SETTLE_CYCLES(T1)) dut1 (
        .clk(clk), .rst(rst[1]), .src_req(req[1]), .src_data(din[1]), .src_ack(ack[1]),
        .m_tdata(dout[1]), .m_tvalid(vld[1]), .m_tready(rdy[1])
`ifdef HANDSHAKE_SYNC_RX_STATUS_EN
        , .xfer_count(cnt[1]), .busy(bsy[1])
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset(input int k);
        rst[k] = 1'b1;
        req[k] = 1'b0;
        rdy[k] = 1'b0;
        din[k] = 8'h00;
        tick();
        tick();
        checks++;
        if (vld[k] !== 1'b0) begin errors++; $display("FAIL reset_vld[%0d] got %b want 0", k, vld[k]); end
        checks++;
        if (ack[k] !== 1'b0) begin errors++; $display("FAIL reset_ack[%0d] got %b want 0", k, ack[k]); end
        checks++;
        if (dout[k] !== 8'h00) begin errors++; $display("FAIL reset_data[%0d] got %h want 00", k, dout[k]); end
`ifdef HANDSHAKE_SYNC_RX_STATUS_EN
        checks++;
        if (cnt[k] !== 16'd0) begin errors++; $display("FAIL reset_count[%0d] got %0d want 0", k, cnt[k]); end
        checks++;
        if (bsy[k] !== 1'b0) begin errors++; $display("FAIL reset_busy[%0d] got %b want 0", k, bsy[k]); end
`endif
        rst[k] = 1'b0;
        tick();
    endtask

    // Toggle src_req with m_tready high and check the exact edge of every output event.
    task automatic test_latency(input int k);
        logic [7:0] d;
        logic       old_ack;
        d       = 8'($urandom);
        old_ack = req[k];
        din[k]  = d;
        rdy[k]  = 1'b1;
        req[k]  = ~req[k];
        for (int e = 1; e <= lat[k] + 2; e++) begin
            tick();
            checks++;
            if (vld[k] !== (e == lat[k])) begin
                errors++; $display("FAIL latency_vld[%0d] edge %0d got %b want %b", k, e, vld[k], (e == lat[k]));
            end
            checks++;
            if (ack[k] !== ((e <= lat[k]) ? old_ack : req[k])) begin
                errors++; $display("FAIL latency_ack[%0d] edge %0d got %b", k, e, ack[k]);
            end
            if (e == lat[k]) begin
                checks++;
                if (dout[k] !== d) begin errors++; $display("FAIL latency_data[%0d] got %h want %h", k, dout[k], d); end
            end
`ifdef HANDSHAKE_SYNC_RX_STATUS_EN
            checks++;
            if (bsy[k] !== (e >= lat[k] - stl[k] && e <= lat[k])) begin
                errors++; $display("FAIL latency_busy[%0d] edge %0d got %b", k, e, bsy[k]);
            end
`endif
        end
    endtask

    task automatic test_backpressure(input int k);
        logic [7:0] d;
        logic       want;
        int         n;
        d      = 8'($urandom);
        din[k] = d;
        rdy[k] = 1'b0;
        req[k] = ~req[k];
        want   = req[k];
        n      = 0;
        while (vld[k] !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (vld[k] !== 1'b1) begin errors++; $display("FAIL bp_timeout[%0d] got vld %b want 1", k, vld[k]); end
        // Once captured, the output must ignore later source-bus activity.
        din[k] = ~d;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (vld[k] !== 1'b1 || dout[k] !== d || ack[k] !== ~want) begin
                errors++;
                $display("FAIL bp_hold[%0d] cycle %0d got vld %b data %h ack %b want 1 %h %b", k, i, vld[k], dout[k], ack[k], d, ~want);
            end
            tick();
        end
        rdy[k] = 1'b1;
        tick();
        checks++;
        if (vld[k] !== 1'b0 || ack[k] !== want) begin
            errors++; $display("FAIL bp_release[%0d] got vld %b ack %b want 0 %b", k, vld[k], ack[k], want);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (vld[k] !== 1'b0) begin errors++; $display("FAIL bp_single[%0d] got vld %b want 0", k, vld[k]); end
        end
        din[k] = d;
    endtask

    task automatic test_back_to_back(input int k);
        logic [7:0] expq [$];
        logic [7:0] want;
        logic [7:0] d;
        logic       v;
        logic       r;
        int         sent;
        int         got;
        int         cyc;
        test_reset(k);
        sent = 0;
        got  = 0;
        cyc  = 0;
        while (got < 32 && cyc < 4000) begin
            rdy[k] = 1'($urandom_range(0, 1));
            if (sent < 32 && ack[k] === req[k]) begin
                din[k] = 8'(sent + 1);
                expq.push_back(8'(sent + 1));
                req[k] = ~req[k];
                sent++;
            end
            v = vld[k];
            r = rdy[k];
            d = dout[k];
            tick();
            cyc++;
            if (v && r) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++; $display("FAIL b2b_extra[%0d] got %h with nothing outstanding", k, d);
                end else begin
                    want = expq.pop_front();
                    if (d !== want) begin errors++; $display("FAIL b2b_word[%0d] got %h want %h", k, d, want); end
                end
                got++;
            end
        end
        checks++;
        if (got != 32) begin errors++; $display("FAIL b2b_count[%0d] got %0d words want 32", k, got); end
        rdy[k] = 1'b1;
        for (int i = 0; i < lat[k] + 3; i++) begin
            tick();
            checks++;
            if (vld[k] !== 1'b0) begin errors++; $display("FAIL b2b_dup[%0d] got vld %b want 0", k, vld[k]); end
        end
`ifdef HANDSHAKE_SYNC_RX_STATUS_EN
        checks++;
        if (cnt[k] !== 16'd32) begin errors++; $display("FAIL b2b_xfer_count[%0d] got %0d want 32", k, cnt[k]); end
`endif
    endtask

    task automatic test_reset_mid(input int k);
        logic [7:0] d;
        int         n;
        test_reset(k);
        d      = 8'($urandom);
        din[k] = d;
        rdy[k] = 1'b0;
        req[k] = 1'b1;
        n      = 0;
        while (vld[k] !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (vld[k] !== 1'b1) begin errors++; $display("FAIL mid_timeout[%0d] got vld %b want 1", k, vld[k]); end
        rst[k] = 1'b1;
        tick();
        checks++;
        if (vld[k] !== 1'b0 || ack[k] !== 1'b0) begin
            errors++; $display("FAIL mid_reset[%0d] got vld %b ack %b want 0 0", k, vld[k], ack[k]);
        end
        rst[k] = 1'b0;
        rdy[k] = 1'b1;
        for (int e = 1; e <= lat[k] + 1; e++) begin
            tick();
            checks++;
            if (vld[k] !== (e == lat[k]) || ack[k] !== (e == lat[k] + 1)) begin
                errors++;
                $display("FAIL mid_redeliver[%0d] edge %0d got vld %b ack %b want %b %b", k, e, vld[k], ack[k], (e == lat[k]), (e == lat[k] + 1));
            end
            if (e == lat[k]) begin
                checks++;
                if (dout[k] !== d) begin errors++; $display("FAIL mid_data[%0d] got %h want %h", k, dout[k], d); end
            end
        end
    endtask

    initial begin
        lat[0] = S0 + 1 + T0;
        lat[1] = S1 + 1 + T1;
        stl[0] = T0;
        stl[1] = T1;
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1;
            req[k] = 1'b0;
            rdy[k] = 1'b0;
            din[k] = 8'h00;
        end
        for (int k = 0; k < 2; k++) begin
            test_reset(k);
            test_latency(k);
            test_latency(k);
            test_backpressure(k);
            test_back_to_back(k);
            test_reset_mid(k);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
